// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter_if
// Brief    : Requester handshakes and register-file write bus of the arbiter.
// Revision : 1.0
// ============================================================================
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
);
    logic                  CORE_WE;
    logic [ADDR_WIDTH-1:0] CORE_ADDR;
    logic [DATA_WIDTH-1:0] CORE_DATA;
    logic                  CORE_READY;
    logic                  DBG_VALID;
    logic [ADDR_WIDTH-1:0] DBG_ADDR;
    logic [DATA_WIDTH-1:0] DBG_DATA;
    logic                  DBG_READY;
    logic                  CLEAR_REQ;
    logic [NUM_REGS-1:0]   RF_WE;
    logic [DATA_WIDTH-1:0] RF_WDATA;
    logic                  BUSY;

    modport master (
        output CORE_WE, CORE_ADDR, CORE_DATA,
        output DBG_VALID, DBG_ADDR, DBG_DATA,
        output CLEAR_REQ,
        input  CORE_READY, DBG_READY,
        input  RF_WE, RF_WDATA, BUSY
    );

    modport slave (
        input  CORE_WE, CORE_ADDR, CORE_DATA,
        input  DBG_VALID, DBG_ADDR, DBG_DATA,
        input  CLEAR_REQ,
        output CORE_READY, DBG_READY,
        output RF_WE, RF_WDATA, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Round-robin core/debug write arbiter with x1..x31 clear sequencer.
// Revision : 1.0
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input logic                  CLK,
    input logic                  RESET,
    regfile_write_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic                  c_gnt_core  = 1'b0;
    localparam logic                  c_gnt_dbg   = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] c_clr_first = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_clr_last  = ADDR_WIDTH'(NUM_REGS - 1);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   clr_idx_q;
    logic                    last_grant_q;
    logic [NUM_REGS-1:0]     rf_we_q;
    logic [DATA_WIDTH-1:0]   rf_wdata_q;

    logic [NUM_REGS-1:0]     rf_we_d;
    logic [DATA_WIDTH-1:0]   rf_wdata_d;

    logic                    w_core_gnt;
    logic                    w_dbg_gnt;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [NUM_REGS-1:0]     w_dec;

    // Grants are withheld during reset, the clear walk and a clear-request cycle.
    always_comb begin
        w_core_gnt = 1'b0;
        w_dbg_gnt  = 1'b0;
        if (!RESET && (state_q == ST_RUN) && !bus.CLEAR_REQ) begin
            if (bus.CORE_WE && bus.DBG_VALID) begin
                w_core_gnt = (last_grant_q == c_gnt_dbg);
                w_dbg_gnt  = (last_grant_q == c_gnt_core);
            end else begin
                w_core_gnt = bus.CORE_WE;
                w_dbg_gnt  = bus.DBG_VALID;
            end
        end
    end

    always_comb begin
        w_sel_addr = bus.DBG_ADDR;
        if (state_q == ST_CLEAR) begin
            w_sel_addr = clr_idx_q;
        end else if (w_core_gnt) begin
            w_sel_addr = bus.CORE_ADDR;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_decode
        assign w_dec[k] = (w_sel_addr == ADDR_WIDTH'(k));
    end

    // x0 is hard-wired zero, so a granted write to it still completes but enables nothing.
    always_comb begin
        rf_we_d    = '0;
        rf_wdata_d = rf_wdata_q;
        if (state_q == ST_CLEAR) begin
            rf_we_d    = w_dec;
            rf_wdata_d = '0;
        end else if (w_core_gnt || w_dbg_gnt) begin
            rf_wdata_d = w_core_gnt ? bus.CORE_DATA : bus.DBG_DATA;
            if (w_sel_addr != '0) begin
                rf_we_d = w_dec;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_CLEAR;
            clr_idx_q    <= c_clr_first;
            last_grant_q <= c_gnt_dbg;
            rf_we_q      <= '0;
            rf_wdata_q   <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_wdata_q <= rf_wdata_d;
            case (state_q)
                ST_CLEAR: begin
                    clr_idx_q <= clr_idx_q + ADDR_WIDTH'(1);
                    if (clr_idx_q == c_clr_last) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.CLEAR_REQ) begin
                        state_q   <= ST_CLEAR;
                        clr_idx_q <= c_clr_first;
                    end else if (w_core_gnt) begin
                        last_grant_q <= c_gnt_core;
                    end else if (w_dbg_gnt) begin
                        last_grant_q <= c_gnt_dbg;
                    end
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    clr_idx_q <= c_clr_first;
                end
            endcase
        end
    end

    assign bus.CORE_READY = w_core_gnt;
    assign bus.DBG_READY  = w_dbg_gnt;
    assign bus.RF_WE      = rf_we_q;
    assign bus.RF_WDATA   = rf_wdata_q;
    assign bus.BUSY       = RESET || (state_q == ST_CLEAR);

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the register-file write port. Arbitrates between two write requesters: the core writeback stage and the debug/program-loader port.
- Each granted write is converted into a registered one-hot write-enable vector plus write data, which drive the register file.
- Also sequences a register-file clear: it zeroes x1..x31 after reset and whenever a clear is requested.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, register address width.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- CORE_WE  input  1  core write request (valid).
- CORE_ADDR  input  ADDR_WIDTH  core destination register.
- CORE_DATA  input  DATA_WIDTH  core write data.
- CORE_READY  output  1  core request granted this cycle.
- DBG_VALID  input  1  debug write request.
- DBG_ADDR  input  ADDR_WIDTH  debug destination register.
- DBG_DATA  input  DATA_WIDTH  debug write data.
- DBG_READY  output  1  debug request granted this cycle.
- CLEAR_REQ  input  1  request a full register clear.
- RF_WE  output  NUM_REGS  registered one-hot write enable to the register file.
- RF_WDATA  output  DATA_WIDTH  registered write data.
- BUSY  output  1  high while the clear sequence is running.

Behaviour:
- Single clock. Reset is synchronous and active-high. Clock port is CLK and reset port is RESET.
- State machine has two states:
  - CLEAR: counter clr_idx walks 1..NUM_REGS-1.
  - RUN: normal arbitration.
- Reset, with RESET high at an edge:
  - state=CLEAR, clr_idx=1, last_grant=DBG.
  - RF_WE=0, RF_WDATA=0.
  - Outputs while RESET is high: CORE_READY=0, DBG_READY=0, BUSY=1.
- CLEAR state:
  - Each cycle, the next edge registers RF_WE = one-hot(clr_idx) and RF_WDATA = 0, then increments clr_idx.
  - On the edge that issues clr_idx = NUM_REGS-1, state becomes RUN.
  - Duration is exactly NUM_REGS-1 (31) cycles. x0 is never written.
  - BUSY=1 and both READY outputs are 0 throughout. Requesters hold their requests.
  - CLEAR_REQ is ignored in this state and does not restart the walk.
  - RESET mid-clear restarts the walk at clr_idx=1.
- Entering CLEAR from RUN: CLEAR_REQ=1 in RUN causes the next state to be CLEAR with clr_idx=1.
  - In that cycle, no grant is made (both READY=0) and RF_WE=0 is registered.
- Arbitration in RUN, with CLEAR_REQ=0:
  - Only CORE_WE high: CORE_READY=1.
  - Only DBG_VALID high: DBG_READY=1.
  - Both high: the requester not equal to last_grant is granted (round-robin).
  - After reset, core wins the first conflict.
  - last_grant updates to the granted requester on every grant.
- READY is combinational from state, both valids, CLEAR_REQ and last_grant.
- A transfer occurs when valid and READY are both high. The requester may change its request on the following cycle.
- Write latency:
  - Granted request at edge N gives RF_WE = one-hot(addr) and RF_WDATA = data during cycle N+1. The register file captures at edge N+1.
  - When no grant is made, RF_WE=0 on the next cycle and RF_WDATA holds its previous value.
- Address 0: the request is granted and the handshake completes, but RF_WE is registered as 0. Writes to x0 are suppressed.
- At most one bit of RF_WE is ever high.
- Address decode: bit k of RF_WE is high iff addr==k. No out-of-range addresses exist when NUM_REGS=2**ADDR_WIDTH.

Test Plan:
- Deassert RESET after 2 cycles -> BUSY=1 for 31 cycles. RF_WE steps 0x0000_0002, 0x0000_0004 … 0x8000_0000 with RF_WDATA=0. Then BUSY=0 and RF_WE=0.
- In RUN, CORE_WE=1, CORE_ADDR=5, CORE_DATA=0xDEAD_BEEF for 1 cycle -> CORE_READY=1 that cycle. Next cycle RF_WE=0x0000_0020, RF_WDATA=0xDEAD_BEEF. Following cycle RF_WE=0.
- Hold CORE_WE and DBG_VALID high for 4 cycles with addresses 3 and 7 -> grants alternate CORE, DBG, CORE, DBG. RF_WE alternates 0x8, 0x80.
- DBG_VALID=1, DBG_ADDR=0, DBG_DATA=0x1234 -> DBG_READY=1. Next cycle RF_WE=0.
- In RUN, CORE_WE=1 and CLEAR_REQ=1 together -> CORE_READY=0. Next cycle BUSY=1 and the clear walk starts at RF_WE=0x2. CORE_READY is first granted in the cycle after the clear completes.
- Assert RESET at clear step 10 (RF_WE=0x400) -> after release, the walk restarts at RF_WE=0x2 and BUSY stays high for a full 31 cycles.
